// File: rtl/axi_pkg.sv
// Shared AXI field widths, derived channel payload widths and the burst encoding
// used by the channel buffers and the slave models around them.
package axi_pkg;

    localparam int ID_M_W  = 4;
    localparam int ID_S_W  = 8;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;
    localparam int STRB_W  = DATA_W / 8;

    localparam int AW_PLD_W = ID_M_W + ADDR_W + LEN_W + SIZE_W + BURST_W;
    localparam int W_PLD_W  = DATA_W + STRB_W + 1;
    localparam int B_PLD_W  = ID_S_W + RESP_W;
    localparam int AR_PLD_W = AW_PLD_W;
    localparam int R_PLD_W  = ID_S_W + DATA_W + RESP_W + 1;

    typedef enum logic [BURST_W-1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    function automatic bit is_pow2(int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/axi_chan_fifo.sv
// Single valid/ready channel FIFO: every output is a register, so no combinational
// path crosses it. The head entry is preloaded into m_data_q one edge ahead.
module axi_chan_fifo
    import axi_pkg::*;
#(
    parameter int PW    = AW_PLD_W,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [PW-1:0]                s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [PW-1:0]                m_data,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (!is_pow2(DEPTH) || DEPTH < 2 || PW < 1) begin : g_param_err
        $error("axi_chan_fifo: DEPTH must be a power of two >= 2 and PW >= 1");
    end

    logic [PW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s_ready_q, s_ready_d;
    logic          m_valid_q, m_valid_d;
    logic [PW-1:0] m_data_q, m_data_d;
    logic          push, pop;

    assign push = s_valid && s_ready_q;
    assign pop  = m_valid_q && m_ready;

    always_comb begin
        // NOTE: every _d gets its default first so no path through this block infers a latch.
        wr_d     = wr_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        m_data_d = m_data_q;
        if (push) wr_d = wr_q + AW'(1);
        if (pop)  rd_d = rd_q + AW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        s_ready_d = cnt_d < CW'(DEPTH);
        m_valid_d = cnt_d != '0;
        // Next head is the beat being written right now when it lands on the new read slot.
        if (m_valid_d) m_data_d = (push && wr_q == rd_d) ? s_data : mem_q[rd_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    // NOTE: storage is deliberately not reset; validity lives in cnt_q, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= s_data;
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign level   = cnt_q;

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        push |-> cnt_q < CW'(DEPTH));
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        m_valid_q && !m_ready |=> m_valid_q && $stable(m_data_q));

endmodule

// File: rtl/axi_chan_buffer.sv
// NUM_CH independent same-direction AXI channels, each either a registered FIFO
// or, when its BYPASS_MASK bit is set, a plain combinational wire.
module axi_chan_buffer
    import axi_pkg::*;
#(
    parameter int                NUM_CH      = 3,
    parameter int                PW          = AW_PLD_W,
    parameter int                DEPTH       = 2,
    parameter logic [NUM_CH-1:0] BYPASS_MASK = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CH-1:0]                    s_valid,
    output logic [NUM_CH-1:0]                    s_ready,
    input  logic [NUM_CH*PW-1:0]                 s_data,
    output logic [NUM_CH-1:0]                    m_valid,
    input  logic [NUM_CH-1:0]                    m_ready,
    output logic [NUM_CH*PW-1:0]                 m_data,
    output logic [NUM_CH*$clog2(DEPTH+1)-1:0]    level
);

    localparam int CW = $clog2(DEPTH + 1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        if (BYPASS_MASK[i]) begin : g_bypass
            assign m_valid[i]            = s_valid[i];
            assign s_ready[i]            = m_ready[i];
            assign m_data[i*PW +: PW]    = s_data[i*PW +: PW];
            assign level[i*CW +: CW]     = '0;
        end else begin : g_fifo
            axi_chan_fifo #(
                .PW    (PW),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .s_valid (s_valid[i]),
                .s_ready (s_ready[i]),
                .s_data  (s_data[i*PW +: PW]),
                .m_valid (m_valid[i]),
                .m_ready (m_ready[i]),
                .m_data  (m_data[i*PW +: PW]),
                .level   (level[i*CW +: CW])
            );
        end
    end

endmodule

// File: tb/tb_axi_chan_buffer.sv
// Self-checking bench: per-channel queue model of the buffer, directed scenarios
// plus a long randomized valid/ready run; a second instance exercises bypass.
module tb_axi_chan_buffer;

    localparam int NUM_CH = 3;
    localparam int PW     = 49;
    localparam int DEPTH  = 2;
    localparam int CW     = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_CH-1:0]    s_valid, s_ready, m_valid, m_ready;
    logic [NUM_CH-1:0]    bp_s_ready, bp_m_valid;
    logic [NUM_CH*PW-1:0] s_data, m_data, bp_m_data;
    logic [NUM_CH*CW-1:0] level, bp_level;

    int errors = 0;
    int checks = 0;

    // Reference model: one queue of payloads per channel plus the "out of reset" flag.
    logic [PW-1:0] mq [NUM_CH][$];
    bit            mrdy = 1'b0;

    always #5 clk = ~clk;

    axi_chan_buffer #(
        .NUM_CH(NUM_CH), .PW(PW), .DEPTH(DEPTH), .BYPASS_MASK(3'b000)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .level(level)
    );

    axi_chan_buffer #(
        .NUM_CH(NUM_CH), .PW(PW), .DEPTH(DEPTH), .BYPASS_MASK(3'b010)
    ) dut_bp (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(bp_s_ready), .s_data(s_data),
        .m_valid(bp_m_valid), .m_ready(m_ready), .m_data(bp_m_data),
        .level(bp_level)
    );

    function automatic logic [NUM_CH-1:0] exp_valid();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = mq[i].size() > 0;
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_ready();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = mrdy && (mq[i].size() < DEPTH);
        return v;
    endfunction

    function automatic logic [NUM_CH*CW-1:0] exp_level();
        logic [NUM_CH*CW-1:0] l;
        for (int i = 0; i < NUM_CH; i++) l[i*CW +: CW] = CW'(mq[i].size());
        return l;
    endfunction

    function automatic logic [PW-1:0] dout(int ch);
        return m_data[ch*PW +: PW];
    endfunction

    function automatic logic [CW-1:0] lvl(int ch);
        return level[ch*CW +: CW];
    endfunction

    task automatic set_data(int ch, logic [PW-1:0] d);
        s_data[ch*PW +: PW] = d;
    endtask

    // Advance one clock: apply the handshake rules to the model, end on the falling edge.
    task automatic edge_step();
        logic [NUM_CH-1:0]    pu, po;
        logic [NUM_CH*PW-1:0] sd;
        pu = s_valid & exp_ready();
        po = exp_valid() & m_ready;
        sd = s_data;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) mq[i].delete();
            mrdy = 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (po[i]) void'(mq[i].pop_front());
                if (pu[i]) mq[i].push_back(sd[i*PW +: PW]);
            end
            mrdy = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) edge_step();
        checks++; if (s_ready !== 3'b000) begin errors++; $display("FAIL reset_s_ready: got %b exp 000", s_ready); end
        checks++; if (m_valid !== 3'b000) begin errors++; $display("FAIL reset_m_valid: got %b exp 000", m_valid); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %h exp 0", level); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h exp 0", m_data); end
        rst = 1'b0;
        #1;
        checks++; if (s_ready !== 3'b000) begin errors++; $display("FAIL release_s_ready_early: got %b exp 000", s_ready); end
        edge_step();
        checks++; if (s_ready !== 3'b111) begin errors++; $display("FAIL release_s_ready: got %b exp 111", s_ready); end
        checks++; if (m_valid !== 3'b000) begin errors++; $display("FAIL release_m_valid: got %b exp 000", m_valid); end
    endtask

    task automatic test_single_push();
        s_valid = 3'b001;
        m_ready = 3'b000;
        set_data(0, 49'h1_2345_6789);
        edge_step();
        s_valid = 3'b000;
        #1;
        checks++; if (m_valid !== 3'b001) begin errors++; $display("FAIL single_m_valid: got %b exp 001", m_valid); end
        checks++; if (dout(0) !== 49'h1_2345_6789) begin errors++; $display("FAIL single_m_data: got %h exp 123456789", dout(0)); end
        checks++; if (lvl(0) !== CW'(1)) begin errors++; $display("FAIL single_level: got %0d exp 1", lvl(0)); end
        m_ready = 3'b001;
        edge_step();
        checks++; if (m_valid !== 3'b000 || lvl(0) !== CW'(0)) begin
            errors++; $display("FAIL single_drain: got valid %b level %0d exp 000/0", m_valid, lvl(0));
        end
        m_ready = 3'b000;
    endtask

    task automatic test_fill_stall();
        logic [PW-1:0] a, b;
        a = PW'(64'h0_AAAA_0000_1111);
        b = PW'(64'h1_BBBB_0000_2222);
        m_ready = 3'b000;
        s_valid = 3'b010;
        set_data(1, a);
        edge_step();
        set_data(1, b);
        edge_step();
        s_valid = 3'b000;
        #1;
        checks++; if (lvl(1) !== CW'(2)) begin errors++; $display("FAIL fill_level: got %0d exp 2", lvl(1)); end
        checks++; if (s_ready[1] !== 1'b0) begin errors++; $display("FAIL fill_s_ready: got %b exp 0", s_ready[1]); end
        for (int k = 0; k < 10; k++) begin
            edge_step();
            checks++; if (!m_valid[1] || dout(1) !== a) begin
                errors++; $display("FAIL stall_hold cyc%0d: got valid %b data %h exp 1/%h", k, m_valid[1], dout(1), a);
            end
        end
        m_ready = 3'b010;
        edge_step();
        checks++; if (!m_valid[1] || dout(1) !== b) begin
            errors++; $display("FAIL drain_second: got valid %b data %h exp 1/%h", m_valid[1], dout(1), b);
        end
        checks++; if (s_ready[1] !== 1'b1) begin errors++; $display("FAIL drain_s_ready: got %b exp 1", s_ready[1]); end
        edge_step();
        checks++; if (m_valid[1] !== 1'b0 || lvl(1) !== CW'(0)) begin
            errors++; $display("FAIL drain_empty: got valid %b level %0d exp 0/0", m_valid[1], lvl(1));
        end
        m_ready = 3'b000;
    endtask

    task automatic test_throughput();
        int got = 0;
        s_valid = 3'b100;
        m_ready = 3'b100;
        for (int k = 0; k < 100; k++) begin
            set_data(2, PW'(k));
            #1;
            if (k > 0) begin
                checks++; if (m_valid[2] !== 1'b1 || lvl(2) !== CW'(1)) begin
                    errors++; $display("FAIL tput_bubble cyc%0d: got valid %b level %0d exp 1/1", k, m_valid[2], lvl(2));
                end
                if (m_valid[2] === 1'b1) begin
                    checks++; if (dout(2) !== PW'(got)) begin
                        errors++; $display("FAIL tput_order cyc%0d: got %h exp %h", k, dout(2), PW'(got));
                    end
                    got++;
                end
            end
            edge_step();
        end
        checks++; if (got != 99) begin errors++; $display("FAIL tput_count: got %0d exp 99", got); end
        s_valid = 3'b000;
        #1;
        checks++; if (dout(2) !== PW'(99)) begin errors++; $display("FAIL tput_last: got %h exp 63", dout(2)); end
        edge_step();
        checks++; if (m_valid[2] !== 1'b0) begin errors++; $display("FAIL tput_empty: got %b exp 0", m_valid[2]); end
        m_ready = 3'b000;
    endtask

    task automatic test_simultaneous();
        logic [PW-1:0] x, y;
        x = PW'(64'h0_1357_9BDF_0246);
        y = PW'(64'h1_FDB9_7531_8ACE);
        s_valid = 3'b001;
        m_ready = 3'b000;
        set_data(0, x);
        edge_step();
        set_data(0, y);
        m_ready = 3'b001;
        #1;
        checks++; if (lvl(0) !== CW'(1) || dout(0) !== x) begin
            errors++; $display("FAIL simul_pre: got level %0d data %h exp 1/%h", lvl(0), dout(0), x);
        end
        edge_step();
        s_valid = 3'b000;
        #1;
        checks++; if (lvl(0) !== CW'(1) || !m_valid[0] || dout(0) !== y) begin
            errors++; $display("FAIL simul_post: got level %0d valid %b data %h exp 1/1/%h", lvl(0), m_valid[0], dout(0), y);
        end
        edge_step();
        checks++; if (lvl(0) !== CW'(0) || m_valid[0] !== 1'b0) begin
            errors++; $display("FAIL simul_drain: got level %0d valid %b exp 0/0", lvl(0), m_valid[0]);
        end
        m_ready = 3'b000;
    endtask

    task automatic test_random();
        int                pops [NUM_CH];
        int                cyc  = 0;
        bit                done = 1'b0;
        logic [NUM_CH-1:0] ev;
        for (int i = 0; i < NUM_CH; i++) pops[i] = 0;
        while (!done && cyc < 40000) begin
            s_valid = NUM_CH'($urandom_range(0, 7));
            m_ready = NUM_CH'($urandom_range(0, 7));
            for (int i = 0; i < NUM_CH; i++) set_data(i, PW'({$urandom, $urandom}));
            #1;
            ev = exp_valid();
            checks++; if (m_valid !== ev) begin errors++; $display("FAIL rand_m_valid cyc%0d: got %b exp %b", cyc, m_valid, ev); end
            checks++; if (s_ready !== exp_ready()) begin errors++; $display("FAIL rand_s_ready cyc%0d: got %b exp %b", cyc, s_ready, exp_ready()); end
            checks++; if (level !== exp_level()) begin errors++; $display("FAIL rand_level cyc%0d: got %h exp %h", cyc, level, exp_level()); end
            for (int i = 0; i < NUM_CH; i++) begin
                if (ev[i]) begin
                    checks++; if (dout(i) !== mq[i][0]) begin
                        errors++; $display("FAIL rand_data ch%0d cyc%0d: got %h exp %h", i, cyc, dout(i), mq[i][0]);
                    end
                    if (m_ready[i]) pops[i]++;
                end
            end
            checks++; if ({bp_m_valid[1], bp_s_ready[1], bp_m_data[PW +: PW], bp_level[CW +: CW]} !==
                          {s_valid[1], m_ready[1], s_data[PW +: PW], CW'(0)}) begin
                errors++; $display("FAIL rand_bypass cyc%0d: got %b/%b/%h exp %b/%b/%h", cyc,
                                   bp_m_valid[1], bp_s_ready[1], bp_m_data[PW +: PW], s_valid[1], m_ready[1], s_data[PW +: PW]);
            end
            edge_step();
            cyc++;
            done = 1'b1;
            for (int i = 0; i < NUM_CH; i++) if (pops[i] < 10000) done = 1'b0;
        end
        checks++; if (!done) begin errors++; $display("FAIL rand_timeout: got pops %0d/%0d/%0d exp >=10000 each", pops[0], pops[1], pops[2]); end
        s_valid = 3'b000;
        m_ready = 3'b111;
        repeat (DEPTH) edge_step();
        checks++; if (m_valid !== 3'b000) begin errors++; $display("FAIL rand_drain: got %b exp 000", m_valid); end
        m_ready = 3'b000;
    endtask

    task automatic test_bypass_reset();
        logic [PW-1:0] c, d, e, g;
        c = PW'(64'h0_C0C0_C0C0_C0C0);
        d = PW'(64'h1_D0D0_D0D0_D0D0);
        e = PW'(64'h0_EEEE_1234_5678);
        g = PW'(64'h1_0600_0000_0006);
        m_ready = 3'b000;
        s_valid = 3'b001;
        set_data(0, c);
        edge_step();
        set_data(0, d);
        edge_step();
        s_valid = 3'b010;
        m_ready = 3'b010;
        set_data(1, e);
        #1;
        checks++; if (bp_m_valid[1] !== 1'b1 || bp_s_ready[1] !== 1'b1 || bp_m_data[PW +: PW] !== e || bp_level[CW +: CW] !== CW'(0)) begin
            errors++; $display("FAIL bypass_mirror_hi: got %b/%b/%h/%0d exp 1/1/%h/0", bp_m_valid[1], bp_s_ready[1], bp_m_data[PW +: PW], bp_level[CW +: CW], e);
        end
        s_valid = 3'b000;
        m_ready = 3'b000;
        #1;
        checks++; if (bp_m_valid[1] !== 1'b0 || bp_s_ready[1] !== 1'b0) begin
            errors++; $display("FAIL bypass_mirror_lo: got %b/%b exp 0/0", bp_m_valid[1], bp_s_ready[1]);
        end
        checks++; if (lvl(0) !== CW'(2) || dout(0) !== c) begin
            errors++; $display("FAIL prereset_ch0: got level %0d data %h exp 2/%h", lvl(0), dout(0), c);
        end
        rst = 1'b1;
        for (int i = 0; i < NUM_CH; i++) mq[i].delete();
        mrdy = 1'b0;
        #1;
        checks++; if (m_valid !== 3'b000 || level !== '0 || s_ready !== 3'b000 || m_data !== '0) begin
            errors++; $display("FAIL async_reset: got valid %b level %h ready %b data %h exp all zero", m_valid, level, s_ready, m_data);
        end
        s_valid = 3'b010;
        #1;
        checks++; if (bp_m_valid[1] !== 1'b1 || bp_m_data[PW +: PW] !== e) begin
            errors++; $display("FAIL bypass_in_reset: got %b/%h exp 1/%h", bp_m_valid[1], bp_m_data[PW +: PW], e);
        end
        s_valid = 3'b000;
        edge_step();
        rst = 1'b0;
        edge_step();
        checks++; if (m_valid !== 3'b000 || level !== '0 || s_ready !== 3'b111) begin
            errors++; $display("FAIL post_reset: got valid %b level %h ready %b exp 000/0/111", m_valid, level, s_ready);
        end
        s_valid = 3'b001;
        set_data(0, g);
        edge_step();
        s_valid = 3'b000;
        #1;
        checks++; if (m_valid !== 3'b001 || dout(0) !== g || lvl(0) !== CW'(1)) begin
            errors++; $display("FAIL post_reset_push: got valid %b data %h level %0d exp 001/%h/1", m_valid, dout(0), lvl(0), g);
        end
        m_ready = 3'b001;
        edge_step();
        checks++; if (m_valid !== 3'b000) begin errors++; $display("FAIL post_reset_drain: got %b exp 000", m_valid); end
        m_ready = 3'b000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        s_valid = '0;
        m_ready = '0;
        s_data  = '0;
        test_reset();
        test_single_push();
        test_fill_stall();
        test_throughput();
        test_simultaneous();
        test_random();
        test_bypass_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
